// File: rtl/dds_phase_engine.sv
// dds_phase_engine: tick divider, five phase accumulators and a noise LFSR for the DDS generator
module dds_phase_engine #(
  parameter int DIV_RATIO    = 10,
  parameter int ACCUM_LENGTH = 24,
  parameter int DAC_SIZE     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [3:0]              mode_in,
  input  logic [ACCUM_LENGTH-1:0] f0_in,
  input  logic [ACCUM_LENGTH-1:0] f1_in,
  input  logic [ACCUM_LENGTH-1:0] f2_in,
  input  logic [ACCUM_LENGTH-1:0] f3_in,
  input  logic [ACCUM_LENGTH-1:0] f4_in,
  input  logic [23:0]             seed_in,
  input  logic                    sync_in,
  output logic                    tick_out,
  output logic [ACCUM_LENGTH-1:0] phase_out0,
  output logic [ACCUM_LENGTH-1:0] phase_out1,
  output logic [ACCUM_LENGTH-1:0] phase_out2,
  output logic [ACCUM_LENGTH-1:0] phase_out3,
  output logic [ACCUM_LENGTH-1:0] phase_out4,
  output logic [DAC_SIZE-1:0]     psrand_out
);
  localparam int CW = $clog2(DIV_RATIO);
  logic [CW-1:0]           cnt;
  logic [3:0]              mode_q;
  logic [23:0]             lfsr;
  logic                    noise_entry;
  logic [ACCUM_LENGTH-1:0] inc [5];
  logic [ACCUM_LENGTH-1:0] ph  [5];
  assign inc[0] = f0_in;
  assign inc[1] = f1_in;
  assign inc[2] = f2_in;
  assign inc[3] = f3_in;
  assign inc[4] = f4_in;
  assign phase_out0 = ph[0];
  assign phase_out1 = ph[1];
  assign phase_out2 = ph[2];
  assign phase_out3 = ph[3];
  assign phase_out4 = ph[4];
  assign tick_out    = cnt == CW'(DIV_RATIO - 1);
  assign noise_entry = mode_in == 4'd3 && mode_q != 4'd3;
  assign psrand_out  = lfsr[23 -: DAC_SIZE];
  // divider counts 0..DIV_RATIO-1; the terminal count is the tick
  always_ff @(posedge clk_in)
    cnt <= (rst_in || tick_out) ? '0 : cnt + 1'b1;
  // channel 0 runs in every mode but noise, channels 1..4 only in multi-tone; sync clears all
  always_ff @(posedge clk_in)
    for (int i = 0; i < 5; i++)
      if (rst_in || (tick_out && sync_in)) ph[i] <= '0;
      else if (tick_out && (mode_in == 4'd1 || (i == 0 && mode_in != 4'd3))) ph[i] <= ph[i] + inc[i];
  // previous mode, used to detect the first cycle of noise mode
  always_ff @(posedge clk_in)
    mode_q <= rst_in ? 4'd0 : mode_in;
  // seed on noise entry (zero seed would lock up), then step once per tick while in noise
  always_ff @(posedge clk_in)
    if (rst_in) lfsr <= 24'h000001;
    else if (noise_entry) lfsr <= (seed_in == 24'h0) ? 24'h000001 : seed_in;
    else if (mode_in == 4'd3 && tick_out) lfsr <= {lfsr[22:0], lfsr[23] ^ lfsr[22] ^ lfsr[21] ^ lfsr[16]};
endmodule

// File: tb/tb_dds_phase_engine.sv
// tb_dds_phase_engine: table vectors, corner sequences and randomized run against a reference model
module tb_dds_phase_engine;
  localparam int DIV = 10;
  logic        clk = 0, rst = 1, sync = 0;
  logic [3:0]  mode = 0;
  logic [23:0] f [5];
  logic [23:0] seed = 0;
  logic        tick;
  logic [23:0] ph [5];
  logic [11:0] psr;
  int n_tests = 0, n_fail = 0;
  int          m_cnt;
  logic [23:0] m_ph [5];
  logic [23:0] m_lfsr;
  logic [3:0]  m_mq;

  typedef struct {
    logic [3:0]  mode;
    logic [23:0] f0, f1, seed;
    logic        sync;
    int          nt;
    logic [23:0] e0, e1;
    logic [11:0] ep;
  } vec_t;
  vec_t tbl [11];

  dds_phase_engine #(.DIV_RATIO(DIV), .ACCUM_LENGTH(24), .DAC_SIZE(12)) dut (
    .clk_in(clk), .rst_in(rst), .mode_in(mode),
    .f0_in(f[0]), .f1_in(f[1]), .f2_in(f[2]), .f3_in(f[3]), .f4_in(f[4]),
    .seed_in(seed), .sync_in(sync), .tick_out(tick),
    .phase_out0(ph[0]), .phase_out1(ph[1]), .phase_out2(ph[2]), .phase_out3(ph[3]), .phase_out4(ph[4]),
    .psrand_out(psr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit tk;
    tk = (m_cnt == DIV - 1);
    if (rst) begin
      m_cnt = 0;
      foreach (m_ph[i]) m_ph[i] = 0;
      m_lfsr = 24'h1;
      m_mq = 0;
    end else begin
      if (mode == 4'd3 && m_mq != 4'd3) m_lfsr = (seed == 24'h0) ? 24'h1 : seed;
      else if (mode == 4'd3 && tk) m_lfsr = {m_lfsr[22:0], ^(m_lfsr & 24'hE10000)};
      if (tk && sync) foreach (m_ph[i]) m_ph[i] = 0;
      else if (tk)
        foreach (m_ph[i]) if (mode == 4'd1 || (i == 0 && mode != 4'd3)) m_ph[i] = m_ph[i] + f[i];
      m_mq = mode;
      m_cnt = (m_cnt + 1) % DIV;
    end
  endtask

  task automatic check_all();
    check("model_tick", 32'(tick), 32'(m_cnt == DIV - 1));
    for (int i = 0; i < 5; i++) check($sformatf("model_phase%0d", i), 32'(ph[i]), 32'(m_ph[i]));
    check("model_psrand", 32'(psr), 32'(m_lfsr[23:12]));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_ticks(input int n);
    for (int t = 0; t < n; t++) begin
      bit done;
      done = 0;
      for (int c = 0; c < 2 * DIV && !done; c++) begin
        done = (m_cnt == DIV - 1);
        step();
      end
      if (!done) check("tick_timeout", 0, 1);
    end
  endtask

  initial begin
    foreach (f[i]) f[i] = 0;
    tbl[0]  = '{4'd0, 24'h000100, 24'h000010, 24'h0, 1'b0, 3,  24'h000300, 24'h000000, 12'h000};
    tbl[1]  = '{4'd0, 24'h000100, 24'h000010, 24'h0, 1'b1, 1,  24'h000000, 24'h000000, 12'h000};
    tbl[2]  = '{4'd1, 24'h800000, 24'h000010, 24'h0, 1'b0, 1,  24'h800000, 24'h000010, 12'h000};
    tbl[3]  = '{4'd1, 24'h800000, 24'h000010, 24'h0, 1'b0, 1,  24'h000000, 24'h000020, 12'h000};
    tbl[4]  = '{4'd1, 24'h800000, 24'h000010, 24'h0, 1'b0, 3,  24'h800000, 24'h000050, 12'h000};
    tbl[5]  = '{4'd3, 24'h800000, 24'h000010, 24'hC00000, 1'b0, 0, 24'h800000, 24'h000050, 12'hC00};
    tbl[6]  = '{4'd3, 24'h800000, 24'h000010, 24'hC00000, 1'b0, 1, 24'h800000, 24'h000050, 12'h800};
    tbl[7]  = '{4'd3, 24'h800000, 24'h000010, 24'hC00000, 1'b0, 1, 24'h800000, 24'h000050, 12'h000};
    tbl[8]  = '{4'd0, 24'h000000, 24'h000000, 24'h0, 1'b0, 0,  24'h800000, 24'h000050, 12'h000};
    tbl[9]  = '{4'd3, 24'h000000, 24'h000000, 24'h0, 1'b0, 0,  24'h800000, 24'h000050, 12'h000};
    tbl[10] = '{4'd3, 24'h000000, 24'h000000, 24'h0, 1'b0, 12, 24'h800000, 24'h000050, 12'h001};
    // reset held for three clocks
    repeat (3) begin
      step();
      check("rst_tick", 32'(tick), 0);
      check("rst_phase0", 32'(ph[0]), 0);
      check("rst_psrand", 32'(psr), 0);
    end
    rst = 0;
    // ticks on clocks 10, 20, 30 after release
    for (int k = 1; k <= 30; k++) begin
      check("tick_pattern", 32'(tick), 32'(k % 10 == 0));
      step();
    end
    // table vectors
    foreach (tbl[v]) begin
      mode = tbl[v].mode; f[0] = tbl[v].f0; f[1] = tbl[v].f1; seed = tbl[v].seed; sync = tbl[v].sync;
      if (tbl[v].nt == 0) step();
      else wait_ticks(tbl[v].nt);
      sync = 0;
      check($sformatf("vec%0d_phase0", v), 32'(ph[0]), 32'(tbl[v].e0));
      check($sformatf("vec%0d_phase1", v), 32'(ph[1]), 32'(tbl[v].e1));
      check($sformatf("vec%0d_phase2", v), 32'(ph[2]), 0);
      check($sformatf("vec%0d_psrand", v), 32'(psr), 32'(tbl[v].ep));
    end
    // sync on a non-tick cycle is ignored
    mode = 0; f[0] = 24'h000100;
    wait_ticks(1);
    check("run_phase0", 32'(ph[0]), 32'h800100);
    sync = 1;
    step();
    sync = 0;
    check("sync_nontick_phase0", 32'(ph[0]), 32'h800100);
    wait_ticks(1);
    check("after_sync_phase0", 32'(ph[0]), 32'h800200);
    // reset in the middle of noise mode
    mode = 3; seed = 24'h123456;
    repeat (13) step();
    rst = 1;
    step();
    check("midrst_tick", 32'(tick), 0);
    check("midrst_phase0", 32'(ph[0]), 0);
    check("midrst_psrand", 32'(psr), 0);
    rst = 0;
    for (int k = 1; k <= 10; k++) begin
      check("midrst_tick_pattern", 32'(tick), 32'(k == 10));
      step();
    end
    // randomized run against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0)
        case ($urandom_range(0, 5))
          0: mode = 0;
          1, 2: mode = 1;
          3, 4: mode = 3;
          default: mode = 4'($urandom);
        endcase
      if ($urandom_range(0, 7) == 0) foreach (f[i]) f[i] = 24'($urandom);
      seed = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
      sync = ($urandom_range(0, 29) == 0);
      rst = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 0; sync = 0;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
